// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder: MMIO offsets,
// FSM encodings, the latched request payload and a byte-lane merge helper.
package dmem_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NBYTE = XLEN / 8;
  localparam int unsigned OFF_W = 12;

  localparam logic [OFF_W-1:0] MMIO_CONSOLE = 12'h000;
  localparam logic [OFF_W-1:0] MMIO_MTIME   = 12'h008;
  localparam logic [OFF_W-1:0] MMIO_TOHOST  = 12'h010;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_BUSY = 1'b1
  } dm_state_e;

  typedef struct packed {
    logic [NBYTE-1:0] we;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
  } dmem_req_t;

  // Replace the byte lanes of old_word selected by we with those of new_word.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0]  old_word,
                                                  input logic [XLEN-1:0]  new_word,
                                                  input logic [NBYTE-1:0] we);
    logic [XLEN-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(NBYTE); i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO window registers: console output, free-running mtime and the sticky
// tohost halt register, plus the combinational read mux.
module dmem_mmio
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [OFF_W-1:0] offset,
  input  logic [NBYTE-1:0] we,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata,
  output logic             console_valid,
  output logic [7:0]       console_data,
  output logic             halt,
  output logic [XLEN-2:0]  halt_code
);

  logic            write;
  logic [XLEN-1:0] mtime;

  assign write = strobe && (we != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      console_valid <= 1'b0;
      console_data  <= '0;
      mtime         <= '0;
      halt          <= 1'b0;
      halt_code     <= '0;
    end else begin
      console_valid <= 1'b0;
      if (write && offset == MMIO_CONSOLE && we[0]) begin
        console_valid <= 1'b1;
        console_data  <= wdata[7:0];
      end
      // A software load takes priority over the tick in the same cycle.
      if (write && offset == MMIO_MTIME) mtime <= merge_bytes(mtime, wdata, we);
      else                               mtime <= mtime + 64'd1;
      if (write && offset == MMIO_TOHOST && !halt && wdata[0]) begin
        halt      <= 1'b1;
        halt_code <= wdata[XLEN-1:1];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      MMIO_MTIME:  rdata = mtime;
      MMIO_TOHOST: rdata = {halt_code, halt};
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side memory responder: byte-writable word RAM plus MMIO window, with
// optional wait states signalled to the pipeline controller via stallreq_dmem.
module data_sram_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [63:0] MMIO_BASE   = 64'h0000_0000_1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        stallreq_dmem,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        halt,
  output logic [62:0] halt_code
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic        HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

  dm_state_e        state;
  logic [3:0]       cnt;
  dmem_req_t        req_q;
  dmem_req_t        acc_req;
  logic             strobe;
  logic             is_read;
  logic             mmio_sel;
  logic [XLEN-1:0]  off_full;
  logic [AW-1:0]    idx;
  logic [XLEN-1:0]  mmio_rdata;
  logic             unused_addr_lsb;
  logic [XLEN-1:0]  mem [DEPTH];

  // Select live or latched request, decide whether an access happens this edge.
  always_comb begin
    acc_req = '{we: data_sram_we, addr: data_sram_addr, wdata: data_sram_wdata};
    if (state == DM_BUSY) acc_req = req_q;
    strobe        = !rst && ((state == DM_BUSY && cnt == 4'd0) ||
                             (state == DM_IDLE && data_sram_en && !HAS_WAIT));
    stallreq_dmem = !rst && ((state == DM_IDLE && data_sram_en && HAS_WAIT) ||
                             (state == DM_BUSY && cnt != 4'd0));
  end

  assign is_read         = (acc_req.we == '0);
  assign off_full        = {acc_req.addr[XLEN-1:3], 3'b000} - MMIO_BASE;
  assign mmio_sel        = (off_full[XLEN-1:OFF_W] == '0);
  assign idx             = acc_req.addr[3 +: AW];
  assign unused_addr_lsb = ^acc_req.addr[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= DM_IDLE;
      cnt             <= 4'd0;
      req_q           <= '0;
      data_sram_rdata <= '0;
    end else begin
      case (state)
        DM_IDLE: begin
          if (data_sram_en && HAS_WAIT) begin
            state <= DM_BUSY;
            cnt   <= CNT_INIT;
            req_q <= acc_req;
          end
        end
        DM_BUSY: begin
          if (cnt == 4'd0) state <= DM_IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= DM_IDLE;
      endcase
      if (strobe && is_read) data_sram_rdata <= mmio_sel ? mmio_rdata : mem[idx];
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (strobe && !is_read && !mmio_sel) mem[idx] <= merge_bytes(mem[idx], acc_req.wdata, acc_req.we);
  end

  dmem_mmio u_mmio (
    .clk           (clk),
    .rst           (rst),
    .strobe        (strobe && mmio_sel),
    .offset        (off_full[OFF_W-1:0]),
    .we            (acc_req.we),
    .wdata         (acc_req.wdata),
    .rdata         (mmio_rdata),
    .console_valid (console_valid),
    .console_data  (console_data),
    .halt          (halt),
    .halt_code     (halt_code)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: one instance without wait states, one with three.
module tb_data_sram_resp;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en0, en3;
  logic [7:0]  we0, we3;
  logic [63:0] addr0, addr3, wdata0, wdata3, rdata0, rdata3;
  logic        stall0, stall3, cv0, cv3, halt0, halt3;
  logic [7:0]  cd0, cd3;
  logic [62:0] hc0, hc3;

  data_sram_resp #(.DEPTH(1024), .WAIT_CYCLES(0), .MMIO_BASE(BASE)) dut0 (
    .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_we(we0),
    .data_sram_addr(addr0), .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
    .stallreq_dmem(stall0), .console_valid(cv0), .console_data(cd0),
    .halt(halt0), .halt_code(hc0));

  data_sram_resp #(.DEPTH(1024), .WAIT_CYCLES(3), .MMIO_BASE(BASE)) dut3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_we(we3),
    .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
    .stallreq_dmem(stall3), .console_valid(cv3), .console_data(cd3),
    .halt(halt3), .halt_code(hc3));

  typedef struct {
    logic        en;
    logic [7:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    int          dut;
    logic [63:0] exp;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t v[20];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int lat, input logic [63:0] exp, input string name);
    sb_t e;
    e.due = cyc + lat;
    e.dut = dut;
    e.exp = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      if (e.due != cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed got=none exp=%h", e.name, e.exp);
      end else begin
        chk(e.name, (e.dut == 0) ? rdata0 : rdata3, e.exp);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_check();
  endtask

  task automatic drive0(input logic en, input logic [7:0] we, input logic [63:0] addr,
                        input logic [63:0] wdata);
    en0 = en; we0 = we; addr0 = addr; wdata0 = wdata;
    #1 chk("stall0", 64'(stall0), 64'd0);
  endtask

  // Hold one request on dut3 for WAIT_CYCLES+1 cycles; later cycles show alt_addr/~wdata.
  task automatic acc3(input logic [7:0] we, input logic [63:0] addr, input logic [63:0] alt_addr,
                      input logic [63:0] wdata, input logic [63:0] exp, input string name);
    for (int k = 0; k < 4; k++) begin
      cycle();
      en3 = 1'b1; we3 = we;
      addr3  = (k == 0) ? addr : alt_addr;
      wdata3 = (k == 0) ? wdata : ~wdata;
      #1 chk($sformatf("%s_stall%0d", name, k), 64'(stall3), (k < 3) ? 64'd1 : 64'd0);
      if (k == 0 && we == 8'h00) push(3, 4, exp, name);
    end
    cycle();
    en3 = 1'b0;
    #1 chk($sformatf("%s_stall_end", name), 64'(stall3), 64'd0);
  endtask

  function automatic vec_t vw(input logic [7:0] we, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] hold);
    vec_t r;
    r = '{1'b1, we, addr, wdata, hold};
    return r;
  endfunction

  function automatic vec_t vr(input logic [63:0] addr, input logic [63:0] exp);
    vec_t r;
    r = '{1'b1, 8'h00, addr, 64'h0, exp};
    return r;
  endfunction

  initial begin
    v[0]  = vw(8'hFF, 64'h80, 64'h1122334455667788, 64'h0);
    v[1]  = vr(64'h80, 64'h1122334455667788);
    v[2]  = vw(8'h0F, 64'h80, 64'hAAAAAAAA_BBBBBBBB, 64'h1122334455667788);
    v[3]  = vr(64'h80, 64'h11223344_BBBBBBBB);
    v[4]  = vw(8'hFF, 64'h88, 64'h0123456789ABCDEF, 64'h11223344_BBBBBBBB);
    v[5]  = vw(8'h81, 64'h88, 64'hFFFFFFFF_FFFFFFEE, 64'h11223344_BBBBBBBB);
    v[6]  = vr(64'h8D, 64'hFF234567_89ABCDEE);
    v[7]  = vr(64'h2080, 64'h11223344_BBBBBBBB);
    v[8]  = vw(8'hFF, 64'h0FFF_FFF8, 64'hCAFEF00D_12345678, 64'h11223344_BBBBBBBB);
    v[9]  = vw(8'hFF, BASE + 64'h1000, 64'h55556666_77778888, 64'h11223344_BBBBBBBB);
    v[10] = vr(64'h1000, 64'h55556666_77778888);
    v[11] = vr(64'h1FF8, 64'hCAFEF00D_12345678);
    v[12] = '{1'b0, 8'h00, 64'h80, 64'h0, 64'hCAFEF00D_12345678};
    v[13] = vr(64'h80, 64'h11223344_BBBBBBBB);
    v[14] = vr(BASE, 64'h0);
    v[15] = vr(64'h1FF8, 64'hCAFEF00D_12345678);
    v[16] = vw(8'hFF, BASE + 64'h18, 64'hDEADBEEF_DEADBEEF, 64'hCAFEF00D_12345678);
    v[17] = vr(BASE + 64'h18, 64'h0);
    v[18] = vr(64'h88, 64'hFF234567_89ABCDEE);
    v[19] = vr(BASE + 64'hFF8, 64'h0);

    rst = 1'b1;
    en0 = 1'b0; we0 = '0; addr0 = '0; wdata0 = '0;
    en3 = 1'b1; we3 = '0; addr3 = 64'h40; wdata3 = '0;
    cycle();
    cycle();
    #1;
    chk("rst_rdata0", rdata0, 64'h0);
    chk("rst_rdata3", rdata3, 64'h0);
    chk("rst_stall3", 64'(stall3), 64'h0);
    chk("rst_cv0", 64'(cv0), 64'h0);
    chk("rst_cd0", 64'(cd0), 64'h0);
    chk("rst_halt0", 64'(halt0), 64'h0);
    chk("rst_hc0", 64'(hc0), 64'h0);
    cycle();
    rst = 1'b0;
    en3 = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cycle();
      drive0(v[i].en, v[i].we, v[i].addr, v[i].wdata);
      push(0, 1, v[i].exp, $sformatf("vec%0d", i));
    end

    // Console pulse.
    cycle(); drive0(1'b1, 8'h01, BASE, 64'h41);
    cycle(); drive0(1'b0, 8'h00, 64'h0, 64'h0);
    chk("console_valid_hi", 64'(cv0), 64'h1);
    chk("console_data", 64'(cd0), 64'h41);
    cycle();
    chk("console_valid_lo", 64'(cv0), 64'h0);

    // mtime load then reads.
    drive0(1'b1, 8'hFF, BASE + 64'h8, 64'h100);
    cycle(); drive0(1'b1, 8'h00, BASE + 64'h8, 64'h0); push(0, 1, 64'h100, "mtime_load");
    for (int i = 0; i < 8; i++) begin
      cycle(); drive0(1'b0, 8'h00, 64'h0, 64'h0);
    end
    cycle(); drive0(1'b1, 8'h00, BASE + 64'h8, 64'h0); push(0, 1, 64'h109, "mtime_later");
    cycle(); drive0(1'b0, 8'h00, 64'h0, 64'h0);

    // tohost: bit0 clear ignored, set halts, later write ignored.
    cycle(); drive0(1'b1, 8'hFF, BASE + 64'h10, 64'h6);
    cycle(); drive0(1'b1, 8'hFF, BASE + 64'h10, 64'h7);
    chk("halt_bit0_clear", 64'(halt0), 64'h0);
    cycle(); drive0(1'b1, 8'hFF, BASE + 64'h10, 64'h5);
    chk("halt_set", 64'(halt0), 64'h1);
    chk("halt_code", 64'(hc0), 64'h3);
    cycle(); drive0(1'b1, 8'h00, BASE + 64'h10, 64'h0); push(0, 1, 64'h7, "tohost_read");
    chk("halt_code_sticky", 64'(hc0), 64'h3);
    cycle(); drive0(1'b0, 8'h00, 64'h0, 64'h0);

    // Wait-state instance: latched address/data must be used.
    acc3(8'hFF, 64'h40, 64'h48, 64'h01020304_05060708, 64'h0, "w3_a");
    acc3(8'hFF, 64'h48, 64'h40, 64'h11111111_22222222, 64'h0, "w3_b");
    acc3(8'h00, 64'h40, 64'h48, 64'h0, 64'h01020304_05060708, "r3_a");
    acc3(8'h00, 64'h48, 64'h40, 64'h0, 64'h11111111_22222222, "r3_b");

    // Reset during BUSY drops the pending write.
    cycle();
    en3 = 1'b1; we3 = 8'hFF; addr3 = 64'h40; wdata3 = 64'hBADBADBA_DBADBADB;
    #1 chk("rstbusy_stall_pre", 64'(stall3), 64'h1);
    cycle();
    rst = 1'b1;
    #1 chk("rstbusy_stall", 64'(stall3), 64'h0);
    cycle();
    cycle();
    rst = 1'b0;
    en3 = 1'b0;
    #1;
    chk("rst_halt_cleared", 64'(halt0), 64'h0);
    chk("rst_hc_cleared", 64'(hc0), 64'h0);
    chk("rst_rdata3_again", rdata3, 64'h0);
    acc3(8'h00, 64'h40, 64'h48, 64'h0, 64'h01020304_05060708, "r3_after_rst");

    repeat (3) cycle();
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side memory responder for the RV64I pipeline: the slave end of the EX stage's `data_sram_en/we/addr/wdata` request interface. It is built around a byte-writable 64-bit word RAM with a small MMIO window containing a console, `mtime` and `tohost`. Read data returns in time for the MEM stage. Wait-state insertion uses a stall request to the pipeline controller. The block sits between EX/MEM and the pipeline controller, replacing the bare SRAM.

## Interface
- `DEPTH`, 1024: RAM depth in 64-bit words; power of two.
- `WAIT_CYCLES`, 0: stall cycles inserted per access; 0..15.
- `MMIO_BASE`, 64'h0000_0000_1000_0000: base of the 4 KiB MMIO window.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `data_sram_en` in 1: access request.
- `data_sram_we` in 8: byte write enables; nonzero means write.
- `data_sram_addr` in 64: byte address; bits [2:0] ignored.
- `data_sram_wdata` in 64: write data, byte lane i = bits [8i+7:8i].
- `data_sram_rdata` out 64: read data for the completed read.
- `stallreq_dmem` out 1: stall request to the controller.
- `console_valid` out 1: one-cycle pulse on a console write.
- `console_data` out 8: console byte, valid with `console_valid`.
- `halt` out 1: sticky; set by a `tohost` write.
- `halt_code` out 63: `tohost` wdata[63:1].

## Operation
- Decode:
  - Address in [MMIO_BASE, MMIO_BASE+0xFFF] selects MMIO.
  - Any other address selects RAM, index = addr[3 +: log2(DEPTH)]. Out-of-range addresses wrap silently.
- RAM write: each byte lane i is written iff we[i]. A read returns the full 64-bit word; byte selection and extension are the MEM stage's job.
- MMIO offsets:
  - 0x000 console: a write with we[0] pulses `console_valid` and drives wdata[7:0]. A read returns 0.
  - 0x008 mtime: 64-bit counter, +1 every cycle. A write loads the byte lanes per `we`; the write wins over the increment in that cycle. A read returns the value before that edge's increment.
  - 0x010 tohost: a write with wdata[0]=1 sets `halt` and captures `halt_code`. A later write while `halt`=1 is ignored. A read returns {halt_code, halt}.
  - Any other offset reads 0; writes to it are ignored.
- FSM, states IDLE and BUSY, with a 4-bit counter `cnt`:
  - IDLE, en=1, WAIT_CYCLES=0: perform the access at this edge; stay in IDLE.
  - IDLE, en=1, WAIT_CYCLES>0: latch we/addr/wdata; set cnt=WAIT_CYCLES-1; go to BUSY; `stallreq_dmem`=1 this cycle.
  - BUSY, cnt≠0: `stallreq_dmem`=1; decrement cnt.
  - BUSY, cnt=0: `stallreq_dmem`=0; perform the access using the *latched* request; go to IDLE.
  - Live inputs are ignored while in BUSY.
- `stallreq_dmem` is combinational from the state, cnt and en. It is forced to 0 while `rst`=1.
- `data_sram_rdata` updates only on a read access; it holds its value across writes and idle cycles.

## Timing
- Reset values: state=IDLE, cnt=0, `data_sram_rdata`=0, mtime=0, `console_valid`=0, `console_data`=0, `halt`=0, `halt_code`=0, `stallreq_dmem`=0. RAM contents are not reset.
- Read latency: `data_sram_rdata` is valid the cycle after the access edge.
  - WAIT_CYCLES=0: one cycle after the request.
  - WAIT_CYCLES=N: N+1 cycles after the request first appears.
- Stall length: exactly WAIT_CYCLES consecutive cycles per access.
- Back-to-back accesses, no wait states: a write to A at edge k followed by a read of A at edge k+1 returns the new data.
- `console_valid` rises the cycle after the write edge and lasts 1 cycle.
- Reset asserted in BUSY: the FSM goes to IDLE immediately and the pending access is dropped; no RAM or MMIO side effect occurs.
- `halt` is cleared only by reset.

## Structure
- Shared package `dmem_pkg`:
  - MMIO offsets `MMIO_CONSOLE`, `MMIO_MTIME` and `MMIO_TOHOST`.
  - State encodings `DM_IDLE` and `DM_BUSY`.
- Sub-module `dmem_mmio`: console, mtime and tohost registers plus read mux. It takes the access strobe, offset, we, wdata and rdata. The top level holds the FSM, request latch, RAM array and decode.

## Test plan
- WAIT_CYCLES=0:
  - Write 0x1122334455667788 to 0x80 with we=0xFF, then read 0x80: rdata=0x1122334455667788 one cycle after the read; `stallreq_dmem` is never 1.
  - Write we=0x0F, wdata=0xAAAAAAAA_BBBBBBBB to the same word, then read: 0x11223344_BBBBBBBB.
- WAIT_CYCLES=3: hold a read request for 4 cycles, changing addr after cycle 1. `stallreq_dmem`=1,1,1,0, and rdata reflects the originally latched address, valid on cycle 5.
- Console: write 0x41 to MMIO_BASE+0x000 → `console_valid`=1 for exactly 1 cycle with `console_data`=0x41.
- mtime:
  - Write 0x100 to MMIO_BASE+0x008, then read on the next edge: returns 0x100.
  - A read 10 cycles later returns 0x109.
- tohost: write 0x7 to MMIO_BASE+0x010 → `halt`=1 and `halt_code`=3. A later write of 0x5 leaves `halt_code`=3.
- Reset: assert `rst` in BUSY with a pending write to 0x40 → `stallreq_dmem`=0 immediately. A read of 0x40 after reset returns the old contents.
